multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle RV32 control unit.
// A Moore state register walks each instruction through FETCH/DECODE and the
// class-specific execute states. Control outputs are decoded from the current
// state and instruction bits. The one exception is pc_write in BRANCH, which
// also follows the live zero flag.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic [9:0]  alu_control,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        mem_write,
  output logic        reg_write,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [9:0] ALU_ADD = 10'b0000000000;
  localparam logic [9:0] ALU_BEQ = 10'b0000001000;
  localparam logic [9:0] ALU_BNE = 10'b0000001001;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_IMM   = 2'b01;
  localparam logic [1:0] SRC_B_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  state_t     state_q;
  state_t     next_state;
  state_t     dec_state;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7_5 = instr[30];

  // Instruction bits the controller has no use for (register fields, immediates).
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // State register: synchronous reset returns to FETCH from anywhere.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= next_state;
  end

  assign state = state_q;

  // Next-state logic: one state per clock; unknown codes recover to FETCH.
  always_comb begin
    next_state = S_FETCH;
    case (state_q)
      S_FETCH:    next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD,
          OP_STORE:  next_state = S_MEMADR;
          OP_RTYPE:  next_state = S_EXECR;
          OP_ITYPE:  next_state = S_EXECI;
          OP_BRANCH: next_state = S_BRANCH;
          OP_JAL:    next_state = S_JAL;
          default:   next_state = S_FETCH;
        endcase
      end
      S_MEMADR:   next_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  next_state = S_MEMWB;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: next_state = S_FETCH;
      S_EXECR:    next_state = S_ALUWB;
      S_EXECI:    next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_JAL:      next_state = S_ALUWB;
      default:    next_state = S_FETCH;
    endcase
  end

  // While reset is held the outputs already show FETCH. This holds even before
  // the first edge has loaded the state register, so no write strobe can leak
  // out of an arbitrary power-up state.
  assign dec_state = reset ? S_FETCH : state_q;

  // Output decode: every output defaults to zero so unlisted states stay quiet.
  always_comb begin
    alu_control = ALU_ADD;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_RS2;
    result_src  = RES_ALUOUT;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    case (dec_state)
      S_FETCH: begin
        // Latch the instruction and advance PC <= PC + 4 through the live ALU result.
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALURES;
      end
      S_DECODE: begin
        // Speculatively form the branch target (old PC + imm) into ALUOut.
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        result_src = RES_MEMDATA;
      end
      S_MEMWRITE: begin
        mem_write  = 1'b1;
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
      end
      S_EXECR: begin
        alu_src_a   = SRC_A_RS1;
        alu_src_b   = SRC_B_RS2;
        alu_control = {1'b0, funct7_5, 5'b0, funct3};
      end
      S_EXECI: begin
        // Bit 30 of an I-type immediate only selects an arithmetic shift
        // (srai). For addi and similar it is an ordinary immediate bit and
        // must not be decoded as SUB.
        alu_src_a   = SRC_A_RS1;
        alu_src_b   = SRC_B_IMM;
        alu_control = {1'b0, funct7_5 & (funct3 == 3'b101), 5'b0, funct3};
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        result_src = RES_ALUOUT;
      end
      S_BRANCH: begin
        // Compare rs1/rs2. The ALU flags "taken" through zero, and the PC
        // loads the DECODE target from ALUOut in this same cycle.
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        result_src = RES_ALUOUT;
        case (funct3)
          3'b000: begin
            alu_control = ALU_BEQ;
            pc_write    = zero;
          end
          3'b001: begin
            alu_control = ALU_BNE;
            pc_write    = zero;
          end
          default: begin
            alu_control = ALU_ADD;
            pc_write    = 1'b0;
          end
        endcase
      end
      S_JAL: begin
        // Jump to ALUOut (target from DECODE) while the ALU forms old PC + 4
        // for the link write in ALUWB.
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
      end
      default: begin
        alu_control = ALU_ADD;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// its state sequence and compares every control output in every state.
module tb_multicycle_control;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic [9:0]  alu_control;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  result_src;
  logic        adr_src;
  logic        ir_write;
  logic        pc_write;
  logic        mem_write;
  logic        reg_write;
  logic [3:0]  state;

  int checks   = 0;
  int failures = 0;

  multicycle_control dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .zero        (zero),
    .alu_control (alu_control),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .result_src  (result_src),
    .adr_src     (adr_src),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bundle: {state, alu_control, src_a, src_b, result_src, adr_src, ir_write, pc_write, mem_write, reg_write}
  function automatic logic [24:0] ev(input logic [3:0] st, input logic [9:0] ac,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] rs, input logic adr,
                                     input logic irw, input logic pcw,
                                     input logic mw, input logic rw);
    return {st, ac, sa, sb, rs, adr, irw, pcw, mw, rw};
  endfunction

  task automatic chk(input string tag, input logic [24:0] exp);
    logic [24:0] obs;
    #1;
    obs = {state, alu_control, alu_src_a, alu_src_b, result_src,
           adr_src, ir_write, pc_write, mem_write, reg_write};
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Common state vectors
  logic [24:0] V_FETCH, V_DECODE, V_ALUWB, V_MEMADR, V_MEMREAD, V_MEMWB, V_MEMWRITE;

  initial begin
    V_FETCH    = ev(4'd0, 10'd0, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    V_DECODE   = ev(4'd1, 10'd0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    V_ALUWB    = ev(4'd8, 10'd0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    V_MEMADR   = ev(4'd2, 10'd0, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    V_MEMREAD  = ev(4'd3, 10'd0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    V_MEMWB    = ev(4'd4, 10'd0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    V_MEMWRITE = ev(4'd5, 10'd0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    reset = 1'b1;
    instr = 32'h00208033;
    zero  = 1'b0;

    // Reset held for two edges
    tick(); chk("reset_c1", V_FETCH);
    tick(); chk("reset_c2", V_FETCH);
    reset = 1'b0;

    // add: 0,1,6,8,0
    chk("add_fetch", V_FETCH);
    tick(); chk("add_decode", V_DECODE);
    tick(); chk("add_execr", ev(4'd6, 10'd0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(); chk("add_aluwb", V_ALUWB);
    tick(); chk("add_fetch2", V_FETCH);

    // sub
    instr = 32'h40208033;
    tick(); chk("sub_decode", V_DECODE);
    tick(); chk("sub_execr", ev(4'd6, 10'b0100000000, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(); chk("sub_aluwb", V_ALUWB);
    tick(); chk("sub_fetch", V_FETCH);

    // srai
    instr = 32'h40115093;
    tick(); chk("srai_decode", V_DECODE);
    tick(); chk("srai_execi", ev(4'd7, 10'b0100000101, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(); chk("srai_aluwb", V_ALUWB);
    tick(); chk("srai_fetch", V_FETCH);

    // addi with imm bit 10 set: must stay ADD
    instr = 32'hC0010093;
    tick(); chk("addi_decode", V_DECODE);
    tick(); chk("addi_execi", ev(4'd7, 10'd0, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(); chk("addi_aluwb", V_ALUWB);
    tick(); chk("addi_fetch", V_FETCH);

    // lw: 0,1,2,3,4,0
    instr = 32'h0000A183;
    tick(); chk("lw_decode", V_DECODE);
    tick(); chk("lw_memadr", V_MEMADR);
    tick(); chk("lw_memread", V_MEMREAD);
    tick(); chk("lw_memwb", V_MEMWB);
    tick(); chk("lw_fetch", V_FETCH);

    // sw: 0,1,2,5,0
    instr = 32'h0020A023;
    tick(); chk("sw_decode", V_DECODE);
    tick(); chk("sw_memadr", V_MEMADR);
    tick(); chk("sw_memwrite", V_MEMWRITE);
    tick(); chk("sw_fetch", V_FETCH);

    // bne taken
    instr = 32'h00209463;
    zero  = 1'b1;
    tick(); chk("bne_t_decode", V_DECODE);
    tick(); chk("bne_t_branch", ev(4'd9, 10'b0000001001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    // same cycle, zero drops: pc_write follows it combinationally
    zero = 1'b0;
    chk("bne_mealy", ev(4'd9, 10'b0000001001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(); chk("bne_t_fetch", V_FETCH);

    // bne not taken
    tick(); chk("bne_n_decode", V_DECODE);
    tick(); chk("bne_n_branch", ev(4'd9, 10'b0000001001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(); chk("bne_n_fetch", V_FETCH);

    // beq taken
    instr = 32'h00208063;
    zero  = 1'b1;
    tick(); chk("beq_decode", V_DECODE);
    tick(); chk("beq_branch", ev(4'd9, 10'b0000001000, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(); chk("beq_fetch", V_FETCH);

    // blt (funct3=100): unsupported, never taken even with zero=1
    instr = 32'h0020C063;
    tick(); chk("blt_decode", V_DECODE);
    tick(); chk("blt_branch", ev(4'd9, 10'd0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(); chk("blt_fetch", V_FETCH);
    zero = 1'b0;

    // jal: 0,1,10,8,0
    instr = 32'h0000006F;
    tick(); chk("jal_decode", V_DECODE);
    tick(); chk("jal_jal", ev(4'd10, 10'd0, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(); chk("jal_aluwb", V_ALUWB);
    tick(); chk("jal_fetch", V_FETCH);

    // illegal opcode: 0,1,0
    instr = 32'h0000007F;
    tick(); chk("ill_decode", V_DECODE);
    tick(); chk("ill_fetch", V_FETCH);

    // reset in the middle of a load
    instr = 32'h0000A183;
    tick(); chk("rst_lw_decode", V_DECODE);
    tick(); chk("rst_lw_memadr", V_MEMADR);
    tick(); chk("rst_lw_memread", V_MEMREAD);
    reset = 1'b1;
    // state register still MEMREAD, outputs already FETCH decode
    chk("rst_hold_outs", ev(4'd3, 10'd0, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tick(); chk("rst_to_fetch", V_FETCH);
    reset = 1'b0;
    chk("rst_release", V_FETCH);
    tick(); chk("rst_post_decode", V_DECODE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
